// File: rtl/zap_copro_dispatch.sv
// -----------------------------------------------------------------------------
// zap_copro_dispatch
//
// Routes the core's single coprocessor request port to one of up to 16
// coprocessor slots. The CP# field [11:8] of the instruction word selects the
// slot. The block returns a single held completion to predecode. A request to
// an absent coprocessor, or one that runs into the timeout, completes with an
// undef flag.
//
// Ports
//   i_clk          core clock
//   i_reset        synchronous active-high reset
//   i_copro_dav    request valid from predecode, held until done is seen
//   i_copro_word   coprocessor instruction word, valid while i_copro_dav
//   o_copro_done   completion to predecode, held until i_copro_dav falls
//   o_copro_undef  qualifies o_copro_done: absent CP or timeout
//   o_busy         high whenever the sequencer is not idle
//   o_cp_dav       one-hot request to the selected slot
//   o_cp_word      latched instruction word broadcast to all slots
//   o_cp_flush     one-cycle one-hot abort pulse to the selected slot
//   i_cp_done      per-slot completion; only the selected slot is observed
//
// Every output is registered.
// -----------------------------------------------------------------------------
module zap_copro_dispatch #(
    parameter logic [15:0] CP_MASK = 16'h8000,
    parameter int          TIMEOUT = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_copro_dav,
    input  logic [31:0] i_copro_word,
    output logic        o_copro_done,
    output logic        o_copro_undef,
    output logic        o_busy,
    output logic [15:0] o_cp_dav,
    output logic [31:0] o_cp_word,
    output logic [15:0] o_cp_flush,
    input  logic [15:0] i_cp_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Last timer value spent in WAIT before a forced undef completion.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_reg,  state_next;
    logic [3:0]  sel_reg,    sel_next;
    logic [15:0] timer_reg,  timer_next;
    logic [31:0] word_reg,   word_next;
    logic [15:0] cp_dav_reg, cp_dav_next;
    logic [15:0] flush_reg,  flush_next;
    logic        done_reg,   done_next;
    logic        undef_reg,  undef_next;
    logic        busy_reg,   busy_next;

    // One-hot decodes of the latched selection and of the incoming CP# field.
    logic [15:0] sel_onehot;
    logic [15:0] req_onehot;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_decode
            assign sel_onehot[gi] = (sel_reg == 4'(gi));
            assign req_onehot[gi] = (i_copro_word[11:8] == 4'(gi));
        end
    endgenerate

    // Completions from slots other than the selected one are masked off here.
    logic sel_done;
    logic req_present;

    assign sel_done    = |(i_cp_done & sel_onehot);
    assign req_present = |(CP_MASK & req_onehot);

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        timer_next  = timer_reg;
        word_next   = word_reg;
        cp_dav_next = cp_dav_reg;
        flush_next  = '0;
        done_next   = done_reg;
        undef_next  = undef_reg;

        case (state_reg)
            ST_IDLE: begin
                // A done still held from a previous request blocks acceptance.
                if (i_copro_dav && !done_reg) begin
                    word_next = i_copro_word;
                    sel_next  = i_copro_word[11:8];
                    if (req_present) begin
                        state_next  = ST_WAIT;
                        cp_dav_next = req_onehot;
                        timer_next  = '0;
                    end else begin
                        state_next = ST_RESP;
                        done_next  = 1'b1;
                        undef_next = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                // Precedence: pipeline abort, then slot completion, then timeout.
                if (!i_copro_dav) begin
                    state_next  = ST_IDLE;
                    cp_dav_next = '0;
                    flush_next  = sel_onehot;
                end else if (sel_done) begin
                    state_next  = ST_RESP;
                    cp_dav_next = '0;
                    done_next   = 1'b1;
                    undef_next  = 1'b0;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next  = ST_RESP;
                    cp_dav_next = '0;
                    flush_next  = sel_onehot;
                    done_next   = 1'b1;
                    undef_next  = 1'b1;
                end else if (timer_reg != 16'hFFFF) begin
                    timer_next = timer_reg + 16'd1;
                end
            end

            ST_RESP: begin
                // Done is held until predecode releases the request, so a
                // stalled predecode stage cannot miss it.
                if (!i_copro_dav) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b0;
                    undef_next = 1'b0;
                    timer_next = '0;
                end
            end

            default: begin
                state_next  = ST_IDLE;
                cp_dav_next = '0;
                done_next   = 1'b0;
                undef_next  = 1'b0;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg  <= ST_IDLE;
            sel_reg    <= '0;
            timer_reg  <= '0;
            word_reg   <= '0;
            cp_dav_reg <= '0;
            flush_reg  <= '0;
            done_reg   <= 1'b0;
            undef_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            timer_reg  <= timer_next;
            word_reg   <= word_next;
            cp_dav_reg <= cp_dav_next;
            flush_reg  <= flush_next;
            done_reg   <= done_next;
            undef_reg  <= undef_next;
            busy_reg   <= busy_next;
        end
    end

    assign o_copro_done  = done_reg;
    assign o_copro_undef = undef_reg;
    assign o_busy        = busy_reg;
    assign o_cp_dav      = cp_dav_reg;
    assign o_cp_word     = word_reg;
    assign o_cp_flush    = flush_reg;

endmodule
